fsk_tx_scheduler: RTL and testbench

Transmit-side controller for the FSK link. It arbitrates round-robin between two 12-bit word sources and drives the modulator's serial data input (modulator port signal_in) with one framed word at a time. Each frame is a start bit, 12 data bits, optional even parity and stop bit(s). Each bit is held for a fixed number of sysclk cycles so the paired demodulator and deserializer can recover the word.

---
 rtl/fsk_pkg.sv | 23 ++
 rtl/fsk_rr_arbiter2.sv | 45 ++++
 rtl/fsk_tx_scheduler.sv | 140 ++++++++++++++
 tb/tb_fsk_tx_scheduler.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fsk_pkg.sv
// Shared constants for the FSK link (modulator, demodulator, deserializer, tx scheduler).
// Holds the payload width, the bit period in sysclk cycles, the tx framing FSM encoding
// and a helper that gives the frame length in bits.
package fsk_pkg;

    localparam int unsigned DATA_W     = 12;
    localparam int unsigned BIT_CYCLES = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } fsk_state_t;

    // Start bit + payload + optional parity + stop bit(s).
    function automatic int unsigned frame_bits(input int unsigned parity_en,
                                               input int unsigned stop_bits);
        return 1 + DATA_W + parity_en + stop_bits;
    endfunction

endpackage

// File: rtl/fsk_rr_arbiter2.sv
// Two-requester round-robin arbiter for the FSK tx scheduler.
// Ports:
//   sysclk, reset   - clock, asynchronous active-high reset
//   req0, req1      - channel valid flags
//   allow           - scheduler can accept a word this cycle
//   ready0, ready1  - combinational accept strobes
//   grant           - channel currently selected (0 or 1)
// The pointer only moves on a completed handshake, to the channel that lost.
module fsk_rr_arbiter2 (
    input  logic sysclk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic allow,
    output logic ready0,
    output logic ready1,
    output logic grant
);

    logic rr_ptr;
    logic handshake;

    always_comb begin
        // A lone requester wins outright; a tie (or no request) falls back to the pointer.
        if (req0 && !req1) begin
            grant = 1'b0;
        end else if (req1 && !req0) begin
            grant = 1'b1;
        end else begin
            grant = rr_ptr;
        end
        ready0    = allow && !grant;
        ready1    = allow && grant;
        handshake = (ready0 && req0) || (ready1 && req1);
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            rr_ptr <= 1'b0;
        end else if (handshake) begin
            rr_ptr <= ~grant;
        end
    end

endmodule

// File: rtl/fsk_tx_scheduler.sv
// Transmit-side scheduler for the FSK link: picks a word from one of two channels
// (round-robin) and serialises it onto tx_serial as start, data MSB first, optional even
// parity and stop bit(s), each bit held for BIT_CYCLES sysclk cycles.
// Ports:
//   sysclk, reset          - clock, asynchronous active-high reset
//   enable                 - allows new words to be accepted; never aborts a frame
//   chN_valid/data/ready   - word sources, ready is a combinational accept strobe
//   tx_serial              - serial line to the modulator, idles high
//   busy, active_ch        - frame in flight and the channel it came from
//   frame_done             - one-cycle pulse in the first idle cycle after a frame
module fsk_tx_scheduler
    import fsk_pkg::*;
#(
    parameter int unsigned PARITY_EN = 1,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              enable,
    input  logic              ch0_valid,
    input  logic [DATA_W-1:0] ch0_data,
    output logic              ch0_ready,
    input  logic              ch1_valid,
    input  logic [DATA_W-1:0] ch1_data,
    output logic              ch1_ready,
    output logic              tx_serial,
    output logic              busy,
    output logic              active_ch,
    output logic              frame_done
);

    localparam int unsigned CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int unsigned IDX_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_TOP   = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    fsk_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  bit_idx;
    logic [DATA_W-1:0] shift_reg;
    logic              parity_bit;
    logic              grant;
    logic              accept;
    logic [DATA_W-1:0] sel_data;

    fsk_rr_arbiter2 u_arb (
        .sysclk (sysclk),
        .reset  (reset),
        .req0   (ch0_valid),
        .req1   (ch1_valid),
        .allow  ((state == IDLE) && enable),
        .ready0 (ch0_ready),
        .ready1 (ch1_ready),
        .grant  (grant)
    );

    always_comb begin
        accept   = (ch0_ready && ch0_valid) || (ch1_ready && ch1_valid);
        sel_data = grant ? ch1_data : ch0_data;
    end

    // tx_serial is loaded with the next bit on the edge that ends the current one, so the
    // line is always a registered output and every bit lasts exactly BIT_CYCLES cycles.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            tx_serial  <= 1'b1;
            busy       <= 1'b0;
            active_ch  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (state == IDLE) begin
                tx_serial <= 1'b1;
                if (accept) begin
                    shift_reg  <= sel_data;
                    parity_bit <= ^sel_data;
                    active_ch  <= grant;
                    busy       <= 1'b1;
                    tx_serial  <= 1'b0;
                    cnt        <= '0;
                    state      <= START;
                end
            end else if (cnt != CNT_LAST) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
                case (state)
                    START: begin
                        state     <= DATA;
                        bit_idx   <= IDX_TOP;
                        tx_serial <= shift_reg[DATA_W-1];
                    end
                    DATA: begin
                        if (bit_idx == '0) begin
                            // bit_idx is reused as the stop-bit counter
                            bit_idx <= '0;
                            if (PARITY_EN != 0) begin
                                state     <= PARITY;
                                tx_serial <= parity_bit;
                            end else begin
                                state     <= STOP;
                                tx_serial <= 1'b1;
                            end
                        end else begin
                            bit_idx   <= bit_idx - 1'b1;
                            shift_reg <= shift_reg << 1;
                            tx_serial <= shift_reg[DATA_W-2];
                        end
                    end
                    PARITY: begin
                        state     <= STOP;
                        bit_idx   <= '0;
                        tx_serial <= 1'b1;
                    end
                    STOP: begin
                        if (bit_idx == STOP_LAST) begin
                            state      <= IDLE;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        tx_serial <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fsk_tx_scheduler.sv
// Bench for fsk_tx_scheduler: directed steps plus randomized frames checked against a
// bit-level frame model and a round-robin grant model.
module tb_fsk_tx_scheduler;
    import fsk_pkg::*;

    logic        sysclk = 1'b0;
    logic        reset_a = 1'b1;
    logic        reset_b = 1'b1;
    logic        enable = 1'b0;
    logic        ch0_valid = 1'b0;
    logic        ch1_valid = 1'b0;
    logic [11:0] ch0_data = '0;
    logic [11:0] ch1_data = '0;

    logic a_rdy0, a_rdy1, a_tx, a_busy, a_ach, a_done;
    logic b_rdy0, b_rdy1, b_tx, b_busy, b_ach, b_done;

    int   checks = 0;
    int   failures = 0;
    logic sel = 1'b0;
    logic exp_ptr [2];
    logic [11:0] exp_word;
    logic exp_ch;

    logic m_rdy0, m_rdy1, m_tx, m_busy, m_ach, m_done;
    assign m_rdy0 = sel ? b_rdy0 : a_rdy0;
    assign m_rdy1 = sel ? b_rdy1 : a_rdy1;
    assign m_tx   = sel ? b_tx   : a_tx;
    assign m_busy = sel ? b_busy : a_busy;
    assign m_ach  = sel ? b_ach  : a_ach;
    assign m_done = sel ? b_done : a_done;

    fsk_tx_scheduler #(.PARITY_EN(1), .STOP_BITS(1)) dut_a (
        .sysclk(sysclk), .reset(reset_a), .enable(enable),
        .ch0_valid(ch0_valid), .ch0_data(ch0_data), .ch0_ready(a_rdy0),
        .ch1_valid(ch1_valid), .ch1_data(ch1_data), .ch1_ready(a_rdy1),
        .tx_serial(a_tx), .busy(a_busy), .active_ch(a_ach), .frame_done(a_done)
    );

    fsk_tx_scheduler #(.PARITY_EN(0), .STOP_BITS(2)) dut_b (
        .sysclk(sysclk), .reset(reset_b), .enable(enable),
        .ch0_valid(ch0_valid), .ch0_data(ch0_data), .ch0_ready(b_rdy0),
        .ch1_valid(ch1_valid), .ch1_data(ch1_data), .ch1_ready(b_rdy1),
        .tx_serial(b_tx), .busy(b_busy), .active_ch(b_ach), .frame_done(b_done)
    );

    always #5 sysclk = ~sysclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    // Line level for frame bit position idx: start, payload MSB first, parity, stops.
    function automatic logic model_bit(input int idx, input logic [11:0] w, input int pe);
        if (idx == 0) return 1'b0;
        if (idx <= 12) return w[12 - idx];
        if (pe != 0 && idx == 13) return ^w;
        return 1'b1;
    endfunction

    // Present a request in the current idle cycle; the handshake happens on the next edge.
    task automatic accept(input logic v0, input logic v1, input logic [11:0] d0,
                          input logic [11:0] d1);
        logic g;
        enable    = 1'b1;
        ch0_valid = v0;
        ch1_valid = v1;
        ch0_data  = d0;
        ch1_data  = d1;
        #1;
        if (v0 && !v1) g = 1'b0;
        else if (v1 && !v0) g = 1'b1;
        else g = exp_ptr[sel];
        check("ready0", m_rdy0, g == 1'b0);
        check("ready1", m_rdy1, g == 1'b1);
        exp_word     = g ? d1 : d0;
        exp_ch       = g;
        exp_ptr[sel] = ~g;
    endtask

    // Follow one frame cycle by cycle, then check the first idle cycle.
    task automatic run_frame(input int pe, input int sb, input bit scramble, input int drop_at);
        int ncyc;
        ncyc = int'(frame_bits(pe, sb)) * int'(BIT_CYCLES);
        for (int c = 1; c <= ncyc; c++) begin
            tick();
            if (c == drop_at) enable = 1'b0;
            check("tx_bit", m_tx, model_bit((c - 1) / int'(BIT_CYCLES), exp_word, pe));
            check("busy_in_frame", m_busy, 1'b1);
            check("active_ch", m_ach, exp_ch);
            check("ready0_in_frame", m_rdy0, 1'b0);
            check("ready1_in_frame", m_rdy1, 1'b0);
            check("done_in_frame", m_done, 1'b0);
            if (scramble) begin
                ch0_valid = 1'($urandom);
                ch1_valid = 1'($urandom);
                ch0_data  = 12'($urandom);
                ch1_data  = 12'($urandom);
                enable    = 1'($urandom);
            end
        end
        tick();
        check("tx_idle", m_tx, 1'b1);
        check("busy_end", m_busy, 1'b0);
        check("frame_done", m_done, 1'b1);
    endtask

    initial begin
        logic [1:0] v;
        exp_ptr[0] = 1'b0;
        exp_ptr[1] = 1'b0;

        // Reset state
        #12;
        check("rst_tx", a_tx, 1'b1);
        check("rst_busy", a_busy, 1'b0);
        check("rst_ach", a_ach, 1'b0);
        check("rst_done", a_done, 1'b0);
        @(negedge sysclk);
        reset_a = 1'b0;
        tick();

        // Both channels valid from reset: ch0, ch1, ch0 back to back
        accept(1'b1, 1'b1, 12'h001, 12'h002);
        check("rr_first", exp_ch, 1'b0);
        run_frame(1, 1, 1'b0, 0);
        accept(1'b1, 1'b1, 12'h001, 12'h002);
        run_frame(1, 1, 1'b0, 0);
        accept(1'b1, 1'b1, 12'h001, 12'h002);
        run_frame(1, 1, 1'b0, 0);

        // Reset in the middle of the data bits
        accept(1'b1, 1'b0, 12'($urandom), 12'h000);
        for (int i = 0; i < 16 + 5 * 16 + 3; i++) tick();
        check("pre_rst_busy", a_busy, 1'b1);
        ch0_valid = 1'b0;
        ch1_valid = 1'b0;
        #2;
        reset_a = 1'b1;
        #1;
        check("async_rst_tx", a_tx, 1'b1);
        check("async_rst_busy", a_busy, 1'b0);
        check("async_rst_ach", a_ach, 1'b0);
        exp_ptr[0] = 1'b0;
        @(negedge sysclk);
        reset_a = 1'b0;
        tick();

        // Lone ch1 wins despite pointer at ch0, then tie goes to ch0
        accept(1'b0, 1'b1, 12'h000, 12'($urandom));
        run_frame(1, 1, 1'b0, 0);
        accept(1'b1, 1'b1, 12'($urandom), 12'($urandom));
        run_frame(1, 1, 1'b0, 0);

        // Reference word
        accept(1'b1, 1'b0, 12'hA5C, 12'h000);
        run_frame(1, 1, 1'b0, 0);

        // enable dropped 50 cycles into a frame
        accept(1'b1, 1'b1, 12'($urandom), 12'($urandom));
        run_frame(1, 1, 1'b0, 50);
        for (int i = 0; i < 4; i++) begin
            check("ready0_disabled", a_rdy0, 1'b0);
            check("ready1_disabled", a_rdy1, 1'b0);
            tick();
            check("idle_tx_disabled", a_tx, 1'b1);
            check("idle_busy_disabled", a_busy, 1'b0);
        end
        accept(1'b1, 1'b1, 12'($urandom), 12'($urandom));
        run_frame(1, 1, 1'b0, 0);

        // Randomized requests with inputs churning during each frame
        for (int i = 0; i < 8; i++) begin
            v = 2'($urandom_range(1, 3));
            accept(v[0], v[1], 12'($urandom), 12'($urandom));
            run_frame(1, 1, 1'b1, 0);
        end

        // No parity, two stop bits
        ch0_valid = 1'b0;
        ch1_valid = 1'b0;
        sel = 1'b1;
        @(negedge sysclk);
        reset_b = 1'b0;
        tick();
        check("b_rst_tx", b_tx, 1'b1);
        check("b_rst_busy", b_busy, 1'b0);
        accept(1'b1, 1'b0, 12'hFFF, 12'h000);
        run_frame(0, 2, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
